fifo_rd_prefetch: RTL and testbench

First-word-fall-through output stage for the asynchronous FIFO read side. It sits directly downstream of the read pointer handler and the dual-port memory in the rclk domain. It consumes the handler's `empty` flag and the memory's registered read data, and drives `r_en` back to the handler. Its output is a valid/ready stream backed by a 2-entry buffer that sustains one word per cycle.

---
 rtl/fifo_rd_prefetch_if.sv | 30 +++
 rtl/fifo_rd_prefetch.sv | 62 ++++++
 tb/tb_fifo_rd_prefetch.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_prefetch_if.sv
// Read-side handshake bundle for fifo_rd_prefetch: the pointer-handler/memory side
// (empty, rdata, r_en) plus the valid/ready output stream.
interface fifo_rd_prefetch_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  empty;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  r_en;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;

    modport master (
        input  empty,
        input  rdata,
        output r_en,
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        output empty,
        output rdata,
        input  r_en,
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface

// File: rtl/fifo_rd_prefetch.sv
// First-word-fall-through output stage for the async FIFO read side (2-entry skid buffer).
// Optional FIFO_RD_LEVEL_EN adds the buf_level output mirroring the buffered word count.
module fifo_rd_prefetch #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                rclk,
    input  logic                rrst_n,
    fifo_rd_prefetch_if.master  bus
`ifdef FIFO_RD_LEVEL_EN
    ,
    output logic [1:0]          buf_level
`endif
);

    logic [1:0]            cnt;
    logic                  pend;
    logic                  head;
    logic                  tail;
    logic [DATA_WIDTH-1:0] slot [2];

    logic                  pop;
    logic                  push;
    logic [2:0]            credit;

    // Credit counts words already buffered plus the one in flight from memory,
    // less the word leaving this cycle, so a read is only issued when it has a slot.
    always_comb begin
        pop    = (cnt != 2'd0) && bus.m_ready;
        push   = pend;
        credit = {1'b0, cnt} + {2'b00, pend} - {2'b00, pop};
    end

    assign bus.r_en    = !bus.empty && (credit < 3'd2);
    assign bus.m_valid = (cnt != 2'd0);
    assign bus.m_data  = slot[head];

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            cnt     <= 2'd0;
            pend    <= 1'b0;
            head    <= 1'b0;
            tail    <= 1'b0;
            slot[0] <= '0;
            slot[1] <= '0;
        end else begin
            pend <= bus.r_en;
            cnt  <= cnt + {1'b0, push} - {1'b0, pop};
            if (push) begin
                slot[tail] <= bus.rdata;
                tail       <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
        end
    end

`ifdef FIFO_RD_LEVEL_EN
    assign buf_level = cnt;
`endif

endmodule

// File: tb/tb_fifo_rd_prefetch.sv
// Self-checking bench for fifo_rd_prefetch: emulates the upstream FIFO (registered empty,
// registered read data) and scores the output stream against the upstream word order.
module tb_fifo_rd_prefetch;

    logic rclk   = 1'b0;
    logic rrst_n = 1'b0;
    always #5 rclk = ~rclk;

    fifo_rd_prefetch_if #(.DATA_WIDTH(8)) bus ();
`ifdef FIFO_RD_LEVEL_EN
    logic [1:0] buf_level;
`endif

    fifo_rd_prefetch #(.DATA_WIDTH(8)) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .bus       (bus)
`ifdef FIFO_RD_LEVEL_EN
        ,
        .buf_level (buf_level)
`endif
    );

    // Upstream FIFO contents, words already read from it (expected output order),
    // and event counts of the transfer.
    logic [7:0] q  [$];
    logic [7:0] sb [$];
    int  issued, landed, accepted;
    bit  pend_m;
    int  cyc;
    bit  prev_stall;
    int  prev_data;
    bit  last_ren;

    int  n_acc, first_acc, last_acc, n_ren, t_fall;
    bit  ren_fall;

    int  n_checks = 0;
    int  n_pass   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic clear_stats();
        n_acc     = 0;
        first_acc = -1;
        last_acc  = -1;
        n_ren     = 0;
        t_fall    = -1;
        ren_fall  = 1'b0;
    endtask

    task automatic push_word(input logic [7:0] w);
        q.push_back(w);
    endtask

    // One clock cycle: drive m_ready, sample away from the edge, then emulate the
    // upstream registers reacting to r_en at the rising edge.
    task automatic step(input bit rdy);
        bit ren_s, pop_s;
        @(negedge rclk);
        bus.m_ready = rdy;
        #1;
        ren_s = bus.r_en;
        pop_s = bus.m_valid && rdy;
        check_eq("ren_while_empty", int'(ren_s && bus.empty), 0);
        check_eq("m_valid", int'(bus.m_valid), int'((landed - accepted) > 0));
        check_eq("credit", int'((issued - accepted) <= 2), 1);
`ifdef FIFO_RD_LEVEL_EN
        check_eq("buf_level", int'(buf_level), landed - accepted);
`endif
        if (prev_stall) begin
            check_eq("stall_valid", int'(bus.m_valid), 1);
            check_eq("stall_data", int'(bus.m_data), prev_data);
        end
        if (!bus.empty && t_fall < 0) begin
            t_fall   = cyc;
            ren_fall = ren_s;
        end
        if (pop_s) begin
            check_eq("sb_nonempty", int'(sb.size() > 0), 1);
            if (sb.size() > 0) check_eq("m_data", int'(bus.m_data), int'(sb.pop_front()));
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
            n_acc++;
        end
        if (ren_s) n_ren++;
        last_ren   = ren_s;
        prev_stall = bus.m_valid && !rdy;
        prev_data  = int'(bus.m_data);
        @(posedge rclk);
        #1;
        if (pend_m) landed++;
        pend_m = ren_s;
        if (pop_s) accepted++;
        if (ren_s) begin
            bus.rdata = q.pop_front();
            sb.push_back(bus.rdata);
            issued++;
        end else begin
            bus.rdata = 8'($urandom);
        end
        bus.empty = (q.size() == 0);
        cyc++;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((q.size() != 0 || sb.size() != 0 || pend_m) && n < 200) begin
            step(1'b1);
            n++;
        end
        check_eq(tag, int'(q.size() == 0 && sb.size() == 0 && !pend_m), 1);
    endtask

    task automatic model_clear();
        q.delete();
        sb.delete();
        issued     = 0;
        landed     = 0;
        accepted   = 0;
        pend_m     = 1'b0;
        prev_stall = 1'b0;
        bus.empty  = 1'b1;
    endtask

    initial begin
        cyc         = 0;
        bus.empty   = 1'b1;
        bus.rdata   = 8'h00;
        bus.m_ready = 1'b0;
        model_clear();
        clear_stats();
        #1;
        check_eq("rst_valid", int'(bus.m_valid), 0);
        check_eq("rst_data", int'(bus.m_data), 0);
        check_eq("rst_ren", int'(bus.r_en), 0);
`ifdef FIFO_RD_LEVEL_EN
        check_eq("rst_level", int'(buf_level), 0);
`endif
        repeat (3) @(posedge rclk);
        @(negedge rclk);
        rrst_n = 1'b1;
        @(posedge rclk);
        #1;

        // Prefilled 3 words, consumer always ready.
        clear_stats();
        push_word(8'h11); push_word(8'h22); push_word(8'h33);
        repeat (8) step(1'b1);
        check_eq("t1_ren_at_fall", int'(ren_fall), 1);
        check_eq("t1_latency", first_acc - t_fall, 2);
        check_eq("t1_count", n_acc, 3);
        check_eq("t1_back_to_back", last_acc - first_acc, 2);
        check_eq("t1_idle_valid", int'(bus.m_valid), 0);

        // Backpressure: 4 words with consumer stalled.
        clear_stats();
        for (int i = 0; i < 4; i++) push_word(8'($urandom));
        repeat (8) step(1'b0);
        check_eq("t2_ren_pulses", n_ren, 2);
        check_eq("t2_valid", int'(bus.m_valid), 1);
`ifdef FIFO_RD_LEVEL_EN
        check_eq("t2_level", int'(buf_level), 2);
`endif
        step(1'b1);
        check_eq("t2_release_ren", int'(last_ren), 1);
        repeat (6) step(1'b1);
        check_eq("t2_count", n_acc, 4);
        check_eq("t2_back_to_back", last_acc - first_acc, 3);
        drain("t2_drain");

        // Continuous 16-word stream.
        clear_stats();
        for (int i = 0; i < 16; i++) push_word(8'($urandom));
        repeat (24) step(1'b1);
        check_eq("t3_count", n_acc, 16);
        check_eq("t3_latency", first_acc - t_fall, 2);
        check_eq("t3_no_gaps", last_acc - first_acc, 15);

        // Ready toggling every cycle.
        clear_stats();
        for (int i = 0; i < 8; i++) push_word(8'($urandom));
        for (int i = 0; i < 30; i++) step(1'(i % 2));
        check_eq("t4_count", n_acc, 8);
        drain("t4_drain");

        // Reset with the buffer holding a word and another in flight.
        clear_stats();
        for (int i = 0; i < 4; i++) push_word(8'($urandom));
        for (int i = 0; i < 12 && n_ren < 2; i++) step(1'b0);
        check_eq("t5_two_reads", n_ren, 2);
        rrst_n = 1'b0;
        #1;
        check_eq("t5_rst_valid", int'(bus.m_valid), 0);
        check_eq("t5_rst_data", int'(bus.m_data), 0);
`ifdef FIFO_RD_LEVEL_EN
        check_eq("t5_rst_level", int'(buf_level), 0);
`endif
        model_clear();
        repeat (2) @(posedge rclk);
        @(negedge rclk);
        rrst_n = 1'b1;
        @(posedge rclk);
        #1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1);
            check_eq("t5_ren_after_rst", int'(last_ren), 0);
        end

        // Randomized traffic and backpressure.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 2) == 0 && q.size() < 16) begin
                int k;
                k = int'($urandom_range(1, 3));
                for (int j = 0; j < k; j++) push_word(8'($urandom));
            end
            step(1'($urandom_range(0, 3) != 0));
        end
        drain("rand_drain");
        check_eq("rand_all_delivered", accepted, issued);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
